// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text arbiter slice.
package lcd_pkg;

    // Arbiter sequencing: pick a requester, fire sendText, wait for the writer, idle gap.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } arbState_t;

    localparam int LCD_TEXT_W = 128;        // 16 characters x 8 bits, char 0 in MSB byte
    localparam int CLK_FREQ   = 50000000;   // system clock in Hz
    localparam int T10US      = CLK_FREQ / 100000;
    localparam int T50MS      = CLK_FREQ / 20;

    // Larger of two cycle counts, used to size a counter shared by two phases.
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_rr_pick2.sv
// Two-way round-robin pick: the pointed-to requester wins if it is asking,
// otherwise the other one does.
module lcd_rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner,
    output logic       valid
);

    // Favour the requester named by the pointer, fall back to the other one
    always_comb begin
        valid  = |req;
        winner = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/lcd_text_arbiter.sv
// Shares one LCD text writer between two requesters. A round-robin winner has
// its line/text snapshotted, the writer gets a single sendText pulse, and the
// arbiter then waits for the writer's done flag to rise (or a timeout) before
// enforcing an idle gap ahead of the next grant. All outputs are registered.
module lcd_text_arbiter
    import lcd_pkg::*;
#(
    parameter int TEXT_W      = LCD_TEXT_W,
    parameter int TIMEOUT_CYC = T50MS,
    parameter int GAP_CYC     = T10US
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req0,
    input  logic              line0,
    input  logic [TEXT_W-1:0] text0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              line1,
    input  logic [TEXT_W-1:0] text1,
    output logic              gnt1,
    output logic              done1,
    output logic              lcd_send,
    output logic              lcd_line,
    output logic [TEXT_W-1:0] lcd_text,
    input  logic              lcd_done,
    output logic              busy,
    output logic              timeout_err
);

    // Timer (WAIT) and gap counter (GAP) are never live together, so one register serves both.
    localparam int CNT_W = $clog2(maxInt(TIMEOUT_CYC, GAP_CYC) + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    arbState_t         state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              ptr, ptrNext;
    logic              owner, ownerNext;
    logic              doneQ;
    logic              doneEdge;
    logic              pickWinner, pickValid;

    logic              gnt0Next, gnt1Next, done0Next, done1Next;
    logic              sendNext, lineNext, busyNext, errNext;
    logic [TEXT_W-1:0] textNext;

    lcd_rr_pick2 u_pick (
        .req    ({req1, req0}),
        .ptr    (ptr),
        .winner (pickWinner),
        .valid  (pickValid)
    );

    // Writer completion is the rising edge of its done flag; a flag already high does not count.
    assign doneEdge = lcd_done & ~doneQ;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and next values of every registered output/control bit
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        ptrNext   = ptr;
        ownerNext = owner;
        lineNext  = lcd_line;
        textNext  = lcd_text;
        busyNext  = busy;
        gnt0Next  = 1'b0;
        gnt1Next  = 1'b0;
        done0Next = 1'b0;
        done1Next = 1'b0;
        sendNext  = 1'b0;
        errNext   = 1'b0;

        case (state)
            IDLE: begin
                busyNext = 1'b0;
                if (pickValid) begin
                    ownerNext = pickWinner;
                    ptrNext   = ~pickWinner;
                    lineNext  = pickWinner ? line1 : line0;
                    textNext  = pickWinner ? text1 : text0;
                    gnt0Next  = ~pickWinner;
                    gnt1Next  = pickWinner;
                    busyNext  = 1'b1;
                    stateNext = LAUNCH;
                end
            end
            LAUNCH: begin
                // A done edge here belongs to an earlier transfer and is ignored.
                sendNext  = 1'b1;
                cntNext   = '0;
                stateNext = WAIT;
            end
            WAIT: begin
                if (doneEdge) begin
                    done0Next = ~owner;
                    done1Next = owner;
                    cntNext   = '0;
                    stateNext = GAP;
                end else if (cnt >= TO_LAST) begin
                    done0Next = ~owner;
                    done1Next = owner;
                    errNext   = 1'b1;
                    cntNext   = '0;
                    stateNext = GAP;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt >= GAP_LAST) begin
                    busyNext  = 1'b0;
                    cntNext   = '0;
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output, snapshot and bookkeeping registers; all return to zero on reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt         <= '0;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            doneQ       <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            lcd_send    <= 1'b0;
            lcd_line    <= 1'b0;
            lcd_text    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cnt         <= cntNext;
            ptr         <= ptrNext;
            owner       <= ownerNext;
            doneQ       <= lcd_done;
            gnt0        <= gnt0Next;
            gnt1        <= gnt1Next;
            done0       <= done0Next;
            done1       <= done1Next;
            lcd_send    <= sendNext;
            lcd_line    <= lineNext;
            lcd_text    <= textNext;
            busy        <= busyNext;
            timeout_err <= errNext;
        end
    end

endmodule
